tlp_tx_mux: RTL
===============

TLP_TX_MUX -- requirements
Module: tlp_tx_mux

Interface
REQ-001 SHALL have parameter NUM_CHAN, default 2, meaning the number of FPGA->Host TLP source channels (legal range 1..8).
REQ-002 SHALL have parameter ARB_MODE, default tlp_xcvr_pkg::ARB_RR, meaning the arbitration mode: ARB_RR is round-robin; ARB_FIXED is fixed priority with channel 0 highest.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; the first two ports are listed below.
REQ-004 pcieClk_in  input  1  sole clock.
REQ-005 reset_in  input  1  asynchronous, active-high reset.
REQ-006 chData_in  input  NUM_CHAN x 64 (tlp_xcvr_pkg::uint64)  per-channel TLP beat.
REQ-007 chSOP_in  input  NUM_CHAN  per-channel first beat of TLP.
REQ-008 chEOP_in  input  NUM_CHAN  per-channel last beat of TLP.
REQ-009 chValid_in  input  NUM_CHAN  per-channel beat valid.
REQ-010 chReady_out  output  NUM_CHAN  per-channel beat accepted when valid&ready.
REQ-011 txData_out  output  64  merged TLP beat to the PCIe core.
REQ-012 txSOP_out / txEOP_out / txValid_out  output  1 each  merged framing and valid.
REQ-013 txReady_in  input  1  PCIe core accepts beat when valid&ready.
REQ-014 grantChan_out  output  max(1,$clog2(NUM_CHAN))  channel currently or most recently granted.

Function
REQ-015 SHALL use a two-state FSM, IDLE and LOCKED, that switches sources only at packet boundaries and never interleaves beats of two TLPs.
REQ-016 In IDLE, SHALL select the winner among channels with chValid_in&chSOP_in set: in ARB_RR, search upward from (lastGrant+1) mod NUM_CHAN; in ARB_FIXED, take the lowest index.
REQ-017 In IDLE, SHALL accept the winner's SOP beat in the same cycle it is selected, provided the output buffer has space.
REQ-018 An accepted SOP beat without EOP SHALL move the FSM IDLE->LOCKED and set grantChan_out to the winner's index.
REQ-019 An accepted SOP&EOP (single-beat) TLP SHALL leave the FSM in IDLE and update lastGrant.
REQ-020 In LOCKED, only the granted channel's chReady_out SHALL be asserted, and only while the buffer has space; all other channels' chReady_out SHALL be 0.
REQ-021 In LOCKED, an accepted EOP beat SHALL return the FSM to IDLE and update lastGrant.
REQ-022 In IDLE, a channel asserting valid without SOP SHALL be a protocol error: its chReady_out SHALL stay 0 and the beat SHALL never be forwarded.
REQ-023 Any accepted input beat SHALL appear on tx*_out exactly 1 cycle later, if the output is not stalled.
REQ-024 The block SHALL sustain 1 beat/cycle across back-to-back packets from the same or different channels, with no idle bubble.
REQ-025 SHALL hold txData_out, txSOP_out and txEOP_out stable while txValid_out=1 and txReady_in=0.
REQ-026 SHALL buffer input beats in a 2-entry skid buffer, so that chReady_out depends only on registered state and no combinational path runs from txReady_in to chReady_out.
REQ-027 With NUM_CHAN=1, SHALL behave as a 1-cycle registered pass-through that still preserves SOP/EOP framing.

Reset
REQ-028 While reset_in=1, SHALL drive txValid_out, txSOP_out, txEOP_out, txData_out, chReady_out and grantChan_out to 0.
REQ-029 While reset_in=1, SHALL hold the FSM in IDLE, empty the skid buffer and set lastGrant=NUM_CHAN-1, so that channel 0 wins first in ARB_RR.
REQ-030 Reset asserted mid-packet SHALL discard all buffered beats; the truncated TLP is not completed and the FSM SHALL restart in IDLE.

Structure
REQ-031 The ArbMode enum (ARB_RR, ARB_FIXED) SHALL be added to tlp_xcvr_pkg, alongside the existing uint64 type.
REQ-032 The skid buffer SHALL be a sub-module, tlp_skid_buffer, parameterised with a 66-bit payload (data + SOP + EOP).
REQ-033 The arbiter and FSM SHALL live in tlp_tx_mux itself.

Verification
REQ-034 Single channel: NUM_CHAN=2, ch0 sends a 4-beat TLP (data 0x10..0x13) with txReady_in=1 -> tx emits 0x10..0x13 on consecutive cycles, SOP on 0x10, EOP on 0x13, first beat 1 cycle after acceptance.
REQ-035 Round-robin contention: ch0 and ch1 each continuously offer 2-beat TLPs -> output order is ch0,ch1,ch0,ch1 with no gap cycles and no interleaving within a TLP.
REQ-036 Fixed-priority starvation: ARB_FIXED, ch0 and ch1 both continuously valid -> only ch0 packets appear; ch1 is granted on the first IDLE cycle after ch0 drops valid.
REQ-037 Backpressure: txReady_in toggled 1,0,0,1 mid-packet -> tx* outputs stay stable while stalled; no beat is lost or duplicated; chReady_out deasserts within 1 cycle once the buffer is full.
REQ-038 Protocol error: ch1 asserts valid without SOP while the FSM is IDLE -> chReady_out[1]=0 and nothing is forwarded from ch1.
REQ-039 Reset mid-packet: reset_in pulsed after beat 2 of a 4-beat TLP -> all outputs are 0 during reset; after release, a new ch0 TLP is forwarded cleanly.

Source files
------------

// File: rtl/tlp_xcvr_pkg.sv
// Shared types for the TLP transceiver: the 64-bit beat type, arbitration
// modes and the FSM state visible on the mux debug port.
package tlp_xcvr_pkg;

  typedef logic [63:0] uint64;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } ArbMode;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } MuxState;

  // Buffered beat layout: {sop, eop, data}
  localparam int PAYLOAD_W = 66;

  function automatic logic [PAYLOAD_W-1:0] packBeat(input logic sop, input logic eop,
                                                    input uint64 data);
    return {sop, eop, data};
  endfunction

endpackage

// File: rtl/tlp_tx_mux_if.sv
// Generic beat stream with framing carried inside the payload.
// A beat transfers on the rising clock edge where valid && ready are both 1;
// valid never depends on ready, and payload is held while valid && !ready.
interface tlp_tx_mux_if #(
  parameter int WIDTH = 66
);
  logic [WIDTH-1:0] payload;
  logic             valid;
  logic             ready;

  modport master (output payload, output valid, input ready);
  modport slave  (input payload, input valid, output ready);
endinterface

// File: rtl/tlp_skid_buffer.sv
// Two-entry skid buffer. Upstream ready is a flop, so there is no
// combinational path from downstream ready back to upstream ready.
module tlp_skid_buffer #(
  parameter int WIDTH = 66
) (
  input  logic          clk,
  input  logic          rst,
  tlp_tx_mux_if.slave   inBus,
  tlp_tx_mux_if.master  outBus
);

  logic [WIDTH-1:0] mem [2];
  logic             wrPtr;
  logic             rdPtr;
  logic [1:0]       count;
  logic [1:0]       countNext;
  logic             spaceReg;
  logic             push;
  logic             pop;

  assign push      = inBus.valid && spaceReg;
  assign pop       = outBus.valid && outBus.ready;
  assign countNext = count + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= 2'd0;
      wrPtr    <= 1'b0;
      rdPtr    <= 1'b0;
      spaceReg <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      count    <= countNext;
      spaceReg <= (countNext != 2'd2);
      if (push) begin
        mem[wrPtr] <= inBus.payload;
        wrPtr      <= ~wrPtr;
      end
      if (pop) rdPtr <= ~rdPtr;
    end
  end

  assign inBus.ready    = spaceReg;
  assign outBus.valid   = (count != 2'd0);
  assign outBus.payload = mem[rdPtr];

endmodule

// File: rtl/tlp_tx_mux.sv
// Packet-atomic N:1 TLP multiplexer: arbitration on SOP beats only, then the
// granted channel is locked until its EOP beat is accepted.
module tlp_tx_mux
  import tlp_xcvr_pkg::*;
#(
  parameter int               NUM_CHAN = 2,
  parameter tlp_xcvr_pkg::ArbMode ARB_MODE = tlp_xcvr_pkg::ARB_RR,
  localparam int              GW       = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
  input  logic                     pcieClk_in,
  input  logic                     reset_in,
  input  uint64 [NUM_CHAN-1:0]     chData_in,
  input  logic  [NUM_CHAN-1:0]     chSOP_in,
  input  logic  [NUM_CHAN-1:0]     chEOP_in,
  input  logic  [NUM_CHAN-1:0]     chValid_in,
  output logic  [NUM_CHAN-1:0]     chReady_out,
  output uint64                    txData_out,
  output logic                     txSOP_out,
  output logic                     txEOP_out,
  output logic                     txValid_out,
  input  logic                     txReady_in,
  output logic  [GW-1:0]           grantChan_out,
  output MuxState                  fsmState_out
);

  tlp_tx_mux_if #(.WIDTH(PAYLOAD_W)) bufIn ();
  tlp_tx_mux_if #(.WIDTH(PAYLOAD_W)) bufOut ();

  MuxState       state, stateNext;
  logic [GW-1:0] grant, grantNext;
  logic [GW-1:0] lastGrant, lastGrantNext;
  logic          found;
  logic [GW-1:0] winner;
  logic [GW-1:0] sel;
  logic          selOk;
  logic          accept;

  // Only SOP beats compete; RR starts searching just past the last winner.
  always_comb begin
    logic [GW-1:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (ARB_MODE == ARB_FIXED) idx = GW'(i);
      else                       idx = GW'((int'(lastGrant) + 1 + i) % NUM_CHAN);
      if (!found && chValid_in[idx] && chSOP_in[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign sel           = (state == LOCKED) ? grant : winner;
  assign selOk         = (state == LOCKED) || found;
  assign bufIn.valid   = selOk && chValid_in[sel];
  assign bufIn.payload = packBeat(chSOP_in[sel], chEOP_in[sel], chData_in[sel]);
  assign accept        = bufIn.valid && bufIn.ready;

  always_comb begin
    chReady_out = '0;
    for (int i = 0; i < NUM_CHAN; i++)
      chReady_out[i] = selOk && bufIn.ready && (sel == GW'(i));
  end

  always_comb begin
    stateNext     = state;
    grantNext     = grant;
    lastGrantNext = lastGrant;
    case (state)
      IDLE: begin
        if (accept) begin
          grantNext = winner;
          if (chEOP_in[winner]) lastGrantNext = winner;
          else                  stateNext     = LOCKED;
        end
      end
      LOCKED: begin
        if (accept && chEOP_in[grant]) begin
          stateNext     = IDLE;
          lastGrantNext = grant;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // lastGrant resets to the top channel so channel 0 wins the first RR round.
  always_ff @(posedge pcieClk_in or posedge reset_in) begin
    if (reset_in) begin
      state     <= IDLE;
      grant     <= '0;
      lastGrant <= GW'(NUM_CHAN - 1);
    end else begin
      state     <= stateNext;
      grant     <= grantNext;
      lastGrant <= lastGrantNext;
    end
  end

  tlp_skid_buffer #(.WIDTH(PAYLOAD_W)) uSkid (
    .clk    (pcieClk_in),
    .rst    (reset_in),
    .inBus  (bufIn),
    .outBus (bufOut)
  );

  assign bufOut.ready  = txReady_in;
  assign txValid_out   = bufOut.valid;
  assign txData_out    = bufOut.payload[63:0];
  assign txSOP_out     = bufOut.valid && bufOut.payload[65];
  assign txEOP_out     = bufOut.valid && bufOut.payload[64];
  assign grantChan_out = grant;
  assign fsmState_out  = state;

endmodule
